// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control unit for the 16-bit core
// Optional retire counter output is enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int PC_W = 16,
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] instr_in,
    input  logic            zero_flag,
    input  logic            mem_ready,
    input  logic            stall,
    output logic [PC_W-1:0] pc_out,
    output logic [IR_W-1:0] ir_out,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            reg_we,
    output logic            wb_sel,
`ifdef CTRL_RETIRE_CNT_EN
    output logic [15:0]     retire_cnt,
`endif
    output logic            halt
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SL    = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_BZ    = 4'hC;

    state_t          state;
    logic [3:0]      opcode;
    logic [PC_W-1:0] br_off;
    logic [2:0]      dec_alu_op;
    logic            dec_imm;
    logic            dec_wb;
    logic            dec_legal;

    assign opcode = ir_out[IR_W-1 -: 4];
    assign br_off = {{(PC_W-6){ir_out[5]}}, ir_out[5:0]};
    // The write strobe must vanish in the very cycle a stall arrives, so it is gated, not registered.
    assign reg_we = (state == S_WB) && !stall;

    always_comb begin
        dec_alu_op = 3'b000;
        dec_imm    = 1'b0;
        dec_wb     = 1'b0;
        dec_legal  = 1'b1;
        case (opcode)
            OP_NOP:   dec_alu_op = 3'b000;
            OP_ADD:   dec_alu_op = 3'b000;
            OP_SUB:   dec_alu_op = 3'b001;
            OP_OR:    dec_alu_op = 3'b010;
            OP_XOR:   dec_alu_op = 3'b011;
            OP_SL:    dec_alu_op = 3'b100;
            OP_LOAD:  begin dec_imm = 1'b1; dec_wb = 1'b1; end
            OP_STORE: dec_imm = 1'b1;
            OP_BZ:    dec_alu_op = 3'b000;
            default:  dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            pc_out      <= '0;
            ir_out      <= '0;
            alu_op      <= 3'b000;
            alu_src_imm <= 1'b0;
            wb_sel      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            halt        <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (!stall) begin
                    ir_out <= instr_in;
                    pc_out <= pc_out + PC_W'(1);
                    state  <= S_DECODE;
                end
                S_DECODE: if (!stall) begin
                    alu_op      <= dec_alu_op;
                    alu_src_imm <= dec_imm;
                    wb_sel      <= dec_wb;
                    if (!dec_legal) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                    end else if (opcode == OP_NOP) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: if (!stall) begin
                    case (opcode)
                        OP_LOAD:  begin mem_rd <= 1'b1; state <= S_MEM; end
                        OP_STORE: begin mem_wr <= 1'b1; state <= S_MEM; end
                        OP_BZ: begin
                            // pc already points past the branch, so the target is addr+1+off.
                            if (zero_flag) pc_out <= pc_out + br_off;
                            state <= S_FETCH;
                        end
                        default:  state <= S_WB;
                    endcase
                end
                S_MEM: if (mem_ready) begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_WB: if (!stall) state <= S_FETCH;
                S_HALT: halt <= 1'b1;
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE: retire = !stall && (opcode == OP_NOP);
            S_EXEC:   retire = !stall && (opcode == OP_BZ);
            S_MEM:    retire = mem_ready && (opcode == OP_STORE);
            S_WB:     retire = !stall;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + 16'd1;
    end
`endif
endmodule
